ascii_hex_word_parser: RTL and testbench

Streaming parser that takes ASCII characters (typically from a UART receiver) and assembles runs of hexadecimal digits into binary words of up to WORD_NIBBLES nibbles. Digits map to nibbles as follows: '0'-'9' map to 0x0-0x9, and 'A'-'F' / 'a'-'f' map to 0xA-0xF. Tokens are separated by delimiter characters. Each completed token is presented on a valid/ready output port for the downstream command or register-write logic.

---
 rtl/ascii_hex_word_parser.sv | 86 ++++++++
 tb/tb_ascii_hex_word_parser.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_hex_word_parser.sv
// ascii_hex_word_parser: assembles ASCII hex-digit tokens into words on a valid/ready port
module ascii_hex_word_parser #(
  parameter int WORD_NIBBLES = 8
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      char_valid,
  input  logic [7:0]                char_data,
  output logic                      char_ready,
  output logic                      word_valid,
  output logic [4*WORD_NIBBLES-1:0] word_data,
  input  logic                      word_ready,
  output logic                      err_invalid,
  output logic                      err_overflow
);
  localparam int W  = 4*WORD_NIBBLES;
  localparam int CW = $clog2(WORD_NIBBLES+1);
  typedef enum logic [1:0] {IDLE, ACCUM, SKIP, OUT} state_t;
  state_t state, state_n;
  logic [W-1:0] acc, acc_n, data_n;
  logic [CW-1:0] cnt, cnt_n;
  logic inv_n, ovf_n, take, is_dec, is_alpha, is_digit, is_delim, full;
  logic [3:0] nib;
  assign is_dec     = char_data inside {[8'h30:8'h39]};
  assign is_alpha   = char_data inside {[8'h41:8'h46], [8'h61:8'h66]};
  assign is_digit   = is_dec | is_alpha;
  assign is_delim   = char_data inside {8'h20, 8'h09, 8'h0a, 8'h0d, 8'h2c};
  assign nib        = is_dec ? char_data[3:0] : char_data[3:0] + 4'd9;
  assign char_ready = nrst && state != OUT;
  assign word_valid = state == OUT;
  assign take       = char_valid && char_ready;
  assign full       = cnt == CW'(WORD_NIBBLES);
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    data_n  = word_data;
    inv_n   = 1'b0;
    ovf_n   = 1'b0;
    case (state)
      IDLE: if (take) begin
        if (is_digit) begin
          acc_n   = W'(nib);
          cnt_n   = CW'(1);
          state_n = ACCUM;
        end else if (!is_delim) begin
          inv_n   = 1'b1;
          state_n = SKIP;
        end
      end
      ACCUM: if (take) begin
        if (is_digit && !full) begin
          acc_n = (acc << 4) | W'(nib);
          cnt_n = cnt + CW'(1);
        end else begin
          // any token end clears the accumulator; only a delimiter publishes it
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = is_digit;
          inv_n   = !is_digit && !is_delim;
          data_n  = is_delim ? acc : word_data;
          state_n = is_delim ? OUT : SKIP;
        end
      end
      SKIP: if (take && is_delim) state_n = IDLE;
      default: if (word_ready) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      word_data    <= '0;
      err_invalid  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_n;
      acc          <= acc_n;
      cnt          <= cnt_n;
      word_data    <= data_n;
      err_invalid  <= inv_n;
      err_overflow <= ovf_n;
    end
  end
endmodule

// File: tb/tb_ascii_hex_word_parser.sv
// tb_ascii_hex_word_parser: token-level reference model with directed and randomized streams
module tb_ascii_hex_word_parser;
  logic clk = 0, nrst = 0, char_valid = 0, word_ready = 1;
  logic [7:0] char_data = 0;
  logic char_ready, word_valid, err_invalid, err_overflow;
  logic [31:0] word_data;
  int checks = 0, errors = 0;
  int exp_inv = 0, exp_ovf = 0, got_inv = 0, got_ovf = 0;
  int m_cnt = 0;
  logic [31:0] m_val = 0;
  bit m_bad = 0, rand_bp = 0;
  logic [31:0] exp_words[$];

  ascii_hex_word_parser #(.WORD_NIBBLES(8)) dut (
    .clk(clk), .nrst(nrst), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .err_invalid(err_invalid), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rand_bp) word_ready = 1'($urandom_range(0, 1));

  always begin
    @(negedge clk);
    #2;
    if (nrst && word_valid && word_ready) begin
      checks++;
      if (exp_words.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected got=%h want=none", word_data);
      end else begin
        logic [31:0] w;
        w = exp_words.pop_front();
        if (word_data !== w) begin
          errors++;
          $display("FAIL word_data got=%h want=%h", word_data, w);
        end
      end
    end
    if (err_invalid === 1'b1) got_inv++;
    if (err_overflow === 1'b1) got_ovf++;
  end

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  task automatic model_char(input logic [7:0] c);
    int v;
    v = hexval(c);
    if (c == " " || c == 8'h09 || c == 8'h0a || c == 8'h0d || c == ",") begin
      if (!m_bad && m_cnt > 0) exp_words.push_back(m_val);
      m_cnt = 0; m_val = 0; m_bad = 0;
    end else if (v < 0) begin
      if (!m_bad) exp_inv++;
      m_bad = 1;
    end else if (!m_bad) begin
      if (m_cnt == 8) begin
        exp_ovf++;
        m_bad = 1;
      end else begin
        m_val = m_val * 16 + 32'(v);
        m_cnt++;
      end
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_val = 0; m_bad = 0;
    exp_words.delete();
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    char_valid = 1;
    char_data = c;
    while (!char_ready && n <= 200) begin
      @(negedge clk);
      n++;
    end
    if (n > 200) begin
      errors++;
      $display("FAIL send_timeout got=stalled want=accept char=%h", c);
    end else begin
      model_char(c);
      @(negedge clk);
    end
    char_valid = 0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic test_reset();
    nrst = 0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (word_valid !== 0) begin errors++; $display("FAIL rst_word_valid got=%b want=0", word_valid); end
    if (word_data !== 0) begin errors++; $display("FAIL rst_word_data got=%h want=0", word_data); end
    if (err_invalid !== 0) begin errors++; $display("FAIL rst_err_invalid got=%b want=0", err_invalid); end
    if (err_overflow !== 0) begin errors++; $display("FAIL rst_err_overflow got=%b want=0", err_overflow); end
    if (char_ready !== 0) begin errors++; $display("FAIL rst_char_ready got=%b want=0", char_ready); end
    nrst = 1;
    #1;
    checks++;
    if (char_ready !== 1) begin errors++; $display("FAIL rel_char_ready got=%b want=1", char_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    word_ready = 1;
    send_str("1aF\n");
    checks += 3;
    if (word_valid !== 1) begin errors++; $display("FAIL basic_valid_t1 got=%b want=1", word_valid); end
    if (word_data !== 32'h1af) begin errors++; $display("FAIL basic_data got=%h want=000001af", word_data); end
    @(negedge clk);
    if (word_valid !== 0) begin errors++; $display("FAIL basic_valid_t2 got=%b want=0", word_valid); end
    checks++;
    if (char_ready !== 1) begin errors++; $display("FAIL basic_ready_t2 got=%b want=1", char_ready); end
    repeat (3) @(negedge clk);
    checks += 3;
    if (exp_words.size() != 0) begin errors++; $display("FAIL basic_pending got=%0d want=0", exp_words.size()); end
    if (got_inv != exp_inv) begin errors++; $display("FAIL basic_inv got=%0d want=%0d", got_inv, exp_inv); end
    if (got_ovf != exp_ovf) begin errors++; $display("FAIL basic_ovf got=%0d want=%0d", got_ovf, exp_ovf); end
  endtask

  task automatic test_multi();
    send_str("DEADBEEF 0 , \r\n");
    repeat (3) @(negedge clk);
    checks += 3;
    if (exp_words.size() != 0) begin errors++; $display("FAIL multi_pending got=%0d want=0", exp_words.size()); end
    if (got_inv != exp_inv) begin errors++; $display("FAIL multi_inv got=%0d want=%0d", got_inv, exp_inv); end
    if (got_ovf != exp_ovf) begin errors++; $display("FAIL multi_ovf got=%0d want=%0d", got_ovf, exp_ovf); end
  endtask

  task automatic test_overflow();
    int o;
    o = got_ovf;
    send_str("123456789 42 ");
    repeat (3) @(negedge clk);
    checks += 4;
    if (got_ovf - o != 1) begin errors++; $display("FAIL ovf_pulses got=%0d want=1", got_ovf - o); end
    if (exp_words.size() != 0) begin errors++; $display("FAIL ovf_pending got=%0d want=0", exp_words.size()); end
    if (got_inv != exp_inv) begin errors++; $display("FAIL ovf_inv got=%0d want=%0d", got_inv, exp_inv); end
    if (got_ovf != exp_ovf) begin errors++; $display("FAIL ovf_ovf got=%0d want=%0d", got_ovf, exp_ovf); end
  endtask

  task automatic test_invalid();
    int i0;
    i0 = got_inv;
    send_str("12G4 5 ");
    repeat (3) @(negedge clk);
    checks += 4;
    if (got_inv - i0 != 1) begin errors++; $display("FAIL inv_pulses got=%0d want=1", got_inv - i0); end
    if (exp_words.size() != 0) begin errors++; $display("FAIL inv_pending got=%0d want=0", exp_words.size()); end
    if (got_inv != exp_inv) begin errors++; $display("FAIL inv_inv got=%0d want=%0d", got_inv, exp_inv); end
    if (got_ovf != exp_ovf) begin errors++; $display("FAIL inv_ovf got=%0d want=%0d", got_ovf, exp_ovf); end
  endtask

  task automatic test_backpressure();
    word_ready = 0;
    send_str("AB ");
    for (int i = 0; i < 10; i++) begin
      checks += 3;
      if (word_valid !== 1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, word_valid); end
      if (word_data !== 32'hab) begin errors++; $display("FAIL bp_data cyc=%0d got=%h want=000000ab", i, word_data); end
      if (char_ready !== 0) begin errors++; $display("FAIL bp_char_ready cyc=%0d got=%b want=0", i, char_ready); end
      @(negedge clk);
    end
    word_ready = 1;
    @(negedge clk);
    checks += 3;
    if (word_valid !== 0) begin errors++; $display("FAIL bp_release_valid got=%b want=0", word_valid); end
    if (char_ready !== 1) begin errors++; $display("FAIL bp_release_ready got=%b want=1", char_ready); end
    if (exp_words.size() != 0) begin errors++; $display("FAIL bp_pending got=%0d want=0", exp_words.size()); end
  endtask

  task automatic test_reset_mid();
    word_ready = 1;
    send_str("7F");
    nrst = 0;
    model_reset();
    @(negedge clk);
    checks += 4;
    if (word_valid !== 0) begin errors++; $display("FAIL midrst_valid got=%b want=0", word_valid); end
    if (word_data !== 0) begin errors++; $display("FAIL midrst_data got=%h want=0", word_data); end
    if ({err_invalid, err_overflow} !== 2'b00) begin errors++; $display("FAIL midrst_err got=%b want=00", {err_invalid, err_overflow}); end
    if (char_ready !== 0) begin errors++; $display("FAIL midrst_char_ready got=%b want=0", char_ready); end
    nrst = 1;
    word_ready = 0;
    send_str("5 ");
    nrst = 0;
    model_reset();
    @(negedge clk);
    checks++;
    if (word_valid !== 0) begin errors++; $display("FAIL outrst_valid got=%b want=0", word_valid); end
    nrst = 1;
    word_ready = 1;
    send_str(" 3 ");
    repeat (3) @(negedge clk);
    checks += 3;
    if (exp_words.size() != 0) begin errors++; $display("FAIL midrst_pending got=%0d want=0", exp_words.size()); end
    if (got_inv != exp_inv) begin errors++; $display("FAIL midrst_inv got=%0d want=%0d", got_inv, exp_inv); end
    if (got_ovf != exp_ovf) begin errors++; $display("FAIL midrst_ovf got=%0d want=%0d", got_ovf, exp_ovf); end
  endtask

  task automatic test_random();
    string digs = "0123456789abcdefABCDEF";
    string dels = " \t\n\r,";
    string bads = "GZ!x@g/:";
    rand_bp = 1;
    for (int t = 0; t < 60; t++) begin
      int n;
      n = $urandom_range(0, 10);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 15) == 0) send(bads[$urandom_range(0, bads.len() - 1)]);
        send(digs[$urandom_range(0, digs.len() - 1)]);
      end
      if ($urandom_range(0, 7) == 0) send(bads[$urandom_range(0, bads.len() - 1)]);
      send(dels[$urandom_range(0, dels.len() - 1)]);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rand_bp = 0;
    word_ready = 1;
    repeat (4) @(negedge clk);
    checks += 3;
    if (exp_words.size() != 0) begin errors++; $display("FAIL rand_pending got=%0d want=0", exp_words.size()); end
    if (got_inv != exp_inv) begin errors++; $display("FAIL rand_inv got=%0d want=%0d", got_inv, exp_inv); end
    if (got_ovf != exp_ovf) begin errors++; $display("FAIL rand_ovf got=%0d want=%0d", got_ovf, exp_ovf); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_multi();
    test_overflow();
    test_invalid();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
